// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use bubbles,
// redirect squashes and data-memory freezes, plus saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_memRead,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 memwb_flush,
  output logic                 mem_timeout_err,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int unsigned        WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_MEM_WAIT
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic                 r_err;
  logic [CNT_WIDTH-1:0] r_stall;
  logic [CNT_WIDTH-1:0] r_flush;
  logic                 w_load_use;
  logic                 w_freeze;
  logic                 w_redirect_acc;

  assign w_load_use = ex_memRead && (ex_rd != '0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    w_next         = r_state;
    w_freeze       = 1'b0;
    w_redirect_acc = 1'b0;
    pc_en          = 1'b1;
    ifid_en        = 1'b1;
    idex_en        = 1'b1;
    exmem_en       = 1'b1;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    memwb_flush    = 1'b0;

    case (r_state)
      S_INIT: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
        w_next      = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        // Held redirect/load-use inputs are simply re-evaluated once memory releases.
        w_freeze = (r_state == S_RUN) ? (mem_req && !mem_ready) : !mem_ready;
        if (w_freeze) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
          w_next      = S_MEM_WAIT;
        end else begin
          w_next = S_RUN;
          if (ex_redirect) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            w_redirect_acc = 1'b1;
          end else if (w_load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end
      end
      default: w_next = S_INIT;
    endcase

    if (!rstN) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= S_INIT;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_stall    <= '0;
      r_flush    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state != S_INIT) && !pc_en && (r_stall != '1))
        r_stall <= r_stall + CNT_WIDTH'(1);
      if (w_redirect_acc && (r_flush != '1))
        r_flush <= r_flush + CNT_WIDTH'(1);
      if (r_state == S_MEM_WAIT) begin
        if (mem_ready) begin
          r_wait_cnt <= '0;
        end else if (r_wait_cnt == WAIT_LAST) begin
          r_err <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
      end
    end
  end

  assign mem_timeout_err = r_err;
  assign stall_cycles    = r_stall;
  assign flush_count     = r_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two parameterisations driven in lockstep, checked
// against a behavioural model, a vector table and hand-written corner sequences.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       mrd;
    logic       redir;
    logic       mreq;
    logic       mrdy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [6:0] ctl;
  } vec_t;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
  localparam logic [6:0] C_RST  = 7'b0000111;
  localparam logic [6:0] C_INIT = 7'b1111111;
  localparam logic [6:0] C_FRZ  = 7'b0000001;
  localparam logic [6:0] C_RDR  = 7'b1111110;
  localparam logic [6:0] C_LU   = 7'b0011010;
  localparam logic [6:0] C_RUN  = 7'b1111000;

  logic  clk;
  logic  rstN;
  stim_t s;

  logic a_pc, a_ifid, a_idex, a_exmem, a_iff, a_idf, a_mwf, a_err;
  logic b_pc, b_ifid, b_idex, b_exmem, b_iff, b_idf, b_mwf, b_err;
  logic [15:0] a_stall, a_flush;
  logic [1:0]  b_stall, b_flush;
  logic [6:0]  a_ctl, b_ctl;

  assign a_ctl = {a_pc, a_ifid, a_idex, a_exmem, a_iff, a_idf, a_mwf};
  assign b_ctl = {b_pc, b_ifid, b_idex, b_exmem, b_iff, b_idf, b_mwf};

  int checks = 0;
  int errors = 0;

  bit m_init[2];
  bit m_wait[2];
  bit m_err[2];
  int m_waitn[2];
  int m_stall[2];
  int m_flush[2];
  int cmax[2];
  int tmo[2];

  hazard_ctrl #(.CNT_WIDTH(16), .MEM_TIMEOUT(64)) u_a (
    .clk(clk), .rstN(rstN),
    .id_rs1(s.rs1), .id_rs2(s.rs2), .id_use_rs1(s.use1), .id_use_rs2(s.use2),
    .ex_rd(s.rd), .ex_memRead(s.mrd), .ex_redirect(s.redir),
    .mem_req(s.mreq), .mem_ready(s.mrdy),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem),
    .ifid_flush(a_iff), .idex_flush(a_idf), .memwb_flush(a_mwf),
    .mem_timeout_err(a_err), .stall_cycles(a_stall), .flush_count(a_flush)
  );

  hazard_ctrl #(.CNT_WIDTH(2), .MEM_TIMEOUT(4)) u_b (
    .clk(clk), .rstN(rstN),
    .id_rs1(s.rs1), .id_rs2(s.rs2), .id_use_rs1(s.use1), .id_use_rs2(s.use2),
    .ex_rd(s.rd), .ex_memRead(s.mrd), .ex_redirect(s.redir),
    .mem_req(s.mreq), .mem_ready(s.mrdy),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem),
    .ifid_flush(b_iff), .idex_flush(b_idf), .memwb_flush(b_mwf),
    .mem_timeout_err(b_err), .stall_cycles(b_stall), .flush_count(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit mrd, input bit redir,
                               input bit mreq, input bit mrdy);
    stim_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.use1 = u1; v.use2 = u2;
    v.rd = 5'(rd); v.mrd = mrd; v.redir = redir; v.mreq = mreq; v.mrdy = mrdy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_init[k] = 1; m_wait[k] = 0; m_err[k] = 0;
    m_waitn[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
  endtask

  function automatic logic [6:0] exp_ctl(input int k);
    bit lu;
    bit hold;
    lu = s.mrd && (s.rd != 0) && ((s.use1 && s.rd == s.rs1) || (s.use2 && s.rd == s.rs2));
    hold = m_wait[k] ? !s.mrdy : (s.mreq && !s.mrdy);
    if (!rstN)     return C_RST;
    if (m_init[k]) return C_INIT;
    if (hold)      return C_FRZ;
    if (s.redir)   return C_RDR;
    if (lu)        return C_LU;
    return C_RUN;
  endfunction

  task automatic model_advance(input int k, input logic [6:0] e);
    if (!rstN) return;
    if (m_init[k]) begin
      m_init[k] = 0;
      return;
    end
    if (!e[6])     m_stall[k] = (m_stall[k] + 1 > cmax[k]) ? cmax[k] : m_stall[k] + 1;
    if (e == C_RDR) m_flush[k] = (m_flush[k] + 1 > cmax[k]) ? cmax[k] : m_flush[k] + 1;
    if (m_wait[k]) begin
      if (s.mrdy) begin
        m_wait[k] = 0;
        m_waitn[k] = 0;
      end else begin
        m_waitn[k]++;
        if (m_waitn[k] >= tmo[k]) m_err[k] = 1;
      end
    end else if (s.mreq && !s.mrdy) begin
      m_wait[k] = 1;
      m_waitn[k] = 0;
    end
  endtask

  task automatic step(input logic rst_v, input stim_t v);
    logic [6:0] e;
    @(negedge clk);
    rstN = rst_v;
    s = v;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rstN) model_reset(k);
      e = exp_ctl(k);
      if (k == 0) begin
        check("model a_ctl",   32'(a_ctl),   32'(e));
        check("model a_stall", 32'(a_stall), 32'(m_stall[0]));
        check("model a_flush", 32'(a_flush), 32'(m_flush[0]));
        check("model a_err",   32'(a_err),   32'(m_err[0]));
      end else begin
        check("model b_ctl",   32'(b_ctl),   32'(e));
        check("model b_stall", 32'(b_stall), 32'(m_stall[1]));
        check("model b_flush", 32'(b_flush), 32'(m_flush[1]));
        check("model b_err",   32'(b_err),   32'(m_err[1]));
      end
      model_advance(k, e);
    end
  endtask

  task automatic do_reset();
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b1, '0);
    step(1'b1, '0);
  endtask

  vec_t tbl[15];
  stim_t idle;
  stim_t mw;
  stim_t rv;

  initial begin
    rstN = 1'b0;
    s    = '0;
    idle = '0;
    cmax[0] = 65535; cmax[1] = 3;
    tmo[0]  = 64;    tmo[1]  = 4;
    model_reset(0);
    model_reset(1);

    tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0), C_RUN};
    tbl[1]  = '{mk(5,1,1,1,5,1,0,0,0), C_LU};
    tbl[2]  = '{mk(0,0,1,1,0,1,0,0,0), C_RUN};
    tbl[3]  = '{mk(1,5,1,1,5,1,0,0,0), C_LU};
    tbl[4]  = '{mk(5,1,0,1,5,1,0,0,0), C_RUN};
    tbl[5]  = '{mk(5,5,1,1,5,0,0,0,0), C_RUN};
    tbl[6]  = '{mk(5,1,1,0,5,1,1,0,0), C_RDR};
    tbl[7]  = '{mk(2,3,1,1,4,0,1,0,0), C_RDR};
    tbl[8]  = '{mk(7,0,1,0,7,1,0,1,1), C_LU};
    tbl[9]  = '{mk(2,3,1,1,4,0,1,1,0), C_FRZ};
    tbl[10] = '{mk(2,3,1,1,4,0,1,1,1), C_RDR};
    tbl[11] = '{mk(0,0,0,0,0,0,0,1,0), C_FRZ};
    tbl[12] = '{mk(0,0,0,0,0,0,0,1,0), C_FRZ};
    tbl[13] = '{mk(9,9,1,1,9,1,0,1,1), C_LU};
    tbl[14] = '{mk(0,0,0,0,0,0,0,0,0), C_RUN};

    // Reset and first cycles after release
    step(1'b0, idle);
    check("reset ctl", 32'(a_ctl), 32'(C_RST));
    check("reset stall", 32'(a_stall), 32'd0);
    check("reset err", 32'(a_err), 32'd0);
    step(1'b0, idle);
    step(1'b1, idle);
    check("init ctl", 32'(a_ctl), 32'(C_INIT));
    step(1'b1, idle);
    check("run idle ctl", 32'(a_ctl), 32'(C_RUN));
    check("run stall", 32'(a_stall), 32'd0);
    check("run flush", 32'(a_flush), 32'd0);

    for (int i = 0; i < 15; i++) begin
      step(1'b1, tbl[i].s);
      check($sformatf("vec%0d a_ctl", i), 32'(a_ctl), 32'(tbl[i].ctl));
      check($sformatf("vec%0d b_ctl", i), 32'(b_ctl), 32'(tbl[i].ctl));
    end

    // Load-use, then same with x0 destination
    do_reset();
    step(1'b1, mk(5,0,1,0,5,1,0,0,0));
    check("lu ctl", 32'(a_ctl), 32'(C_LU));
    step(1'b1, idle);
    check("lu release", 32'(a_ctl), 32'(C_RUN));
    check("lu stall", 32'(a_stall), 32'd1);
    step(1'b1, mk(0,0,1,0,0,1,0,0,0));
    check("lu x0 ctl", 32'(a_ctl), 32'(C_RUN));
    step(1'b1, idle);
    check("lu x0 stall", 32'(a_stall), 32'd1);

    // Redirect wins over load-use
    do_reset();
    step(1'b1, mk(5,0,1,0,5,1,1,0,0));
    check("rdr+lu ctl", 32'(a_ctl), 32'(C_RDR));
    step(1'b1, idle);
    check("rdr flush", 32'(a_flush), 32'd1);
    check("rdr stall", 32'(a_stall), 32'd0);

    // Three frozen cycles then release
    do_reset();
    mw = mk(0,0,0,0,0,0,0,1,0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mw);
      check($sformatf("mem frz%0d", i), 32'(a_ctl), 32'(C_FRZ));
    end
    step(1'b1, mk(0,0,0,0,0,0,0,1,1));
    check("mem release", 32'(a_ctl), 32'(C_RUN));
    step(1'b1, idle);
    check("mem stall", 32'(a_stall), 32'd3);
    check("mem no err", 32'(b_err), 32'd0);

    // Timeout on the short-timeout instance, then reset mid-wait
    do_reset();
    step(1'b1, mw);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mw);
      check($sformatf("tmo pre%0d", i), 32'(b_err), 32'd0);
    end
    step(1'b1, mw);
    check("tmo set", 32'(b_err), 32'd1);
    check("tmo a clear", 32'(a_err), 32'd0);
    step(1'b1, mw);
    step(1'b1, mw);
    check("tmo sticky", 32'(b_err), 32'd1);
    check("tmo still frozen", 32'(b_ctl), 32'(C_FRZ));
    step(1'b0, mw);
    check("tmo rst err", 32'(b_err), 32'd0);
    check("tmo rst ctl", 32'(b_ctl), 32'(C_RST));
    step(1'b1, mw);
    check("tmo rst init", 32'(b_ctl), 32'(C_INIT));

    // Counter saturation at 2 bits
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, mk(0,0,0,0,0,0,1,0,0));
    step(1'b1, idle);
    check("sat b_flush", 32'(b_flush), 32'd3);
    check("sat a_flush", 32'(a_flush), 32'd5);

    // Randomized run against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rv.rs1   = 5'($urandom_range(0, 3));
      rv.rs2   = 5'($urandom_range(0, 3));
      rv.use1  = ($urandom_range(0, 3) != 0);
      rv.use2  = ($urandom_range(0, 1) != 0);
      rv.rd    = 5'($urandom_range(0, 3));
      rv.mrd   = ($urandom_range(0, 1) != 0);
      rv.redir = ($urandom_range(0, 4) == 0);
      rv.mreq  = ($urandom_range(0, 2) == 0);
      rv.mrdy  = ($urandom_range(0, 9) < 6);
      step(($urandom_range(0, 299) != 0), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
